// File: rtl/entropy_collector_pkg.sv
// -----------------------------------------------------------------------------
// entropy_pkg
// Shared definitions for the entropy collector. It holds the peripheral
// register map, the data-path widths, the collector FSM state encoding and
// the bus request bundle that the FSM registers.
// -----------------------------------------------------------------------------
package entropy_pkg;

    // Data-path widths
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int WORD_W = 2 * DATA_W;

    // Peripheral register map
    localparam logic [ADDR_W-1:0] ADDR_ENT_WR_RNG1      = 8'h00;
    localparam logic [ADDR_W-1:0] ADDR_ENT_WR_RNG2      = 8'h01;
    localparam logic [ADDR_W-1:0] ADDR_ENT_RD_RNG1_RNG2 = 8'h10;
    localparam logic [ADDR_W-1:0] ADDR_ENT_RD_P         = 8'h11;
    localparam logic [ADDR_W-1:0] ADDR_ENT_RD_N         = 8'h12;

    // Collector FSM states
    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_WR1   = 3'd1,
        ST_WR2   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RD_P  = 3'd4,
        ST_RD_N  = 3'd5
    } state_t;

    // One registered peripheral bus request
    typedef struct packed {
        logic              cs;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dwrite;
    } bus_req_t;

endpackage

// File: rtl/entropy_collector_if.sv
// -----------------------------------------------------------------------------
// entropy_collector_if
// Groups the peripheral bus and the random-word stream of the collector.
//   cs/we/addr/dwrite : bus request driven by the collector
//   dread             : combinational read data from the peripheral
//   rnd_data/valid    : FIFO head word and not-empty flag
//   rnd_ready         : consumer accepts the head word
//   rnd_level         : FIFO occupancy
// master = collector side, slave = peripheral/consumer side.
// -----------------------------------------------------------------------------
interface entropy_collector_if
    import entropy_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic               cs;
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  dwrite;
    logic [DATA_W-1:0]  dread;
    logic [WORD_W-1:0]  rnd_data;
    logic               rnd_valid;
    logic               rnd_ready;
    logic [LEVEL_W-1:0] rnd_level;

    modport master (
        output cs, we, addr, dwrite, rnd_data, rnd_valid, rnd_level,
        input  dread, rnd_ready
    );

    modport slave (
        input  cs, we, addr, dwrite, rnd_data, rnd_valid, rnd_level,
        output dread, rnd_ready
    );
endinterface

// File: rtl/entropy_collector_fifo.sv
// -----------------------------------------------------------------------------
// entropy_fifo
// Synchronous show-ahead FIFO. The head entry is always visible on rdata;
// a pop advances the read pointer so the next entry shows one cycle later.
// Ports: clk, nreset (sync, active-low), push/wdata, pop/rdata,
//        full, empty, level (occupancy).
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module entropy_fifo #(
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LEVEL_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               push,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               pop,
    output logic [WIDTH-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == LEVEL_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Memory is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LEVEL_W'(1);
                2'b01:   count <= count - LEVEL_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/entropy_collector.sv
// -----------------------------------------------------------------------------
// entropy_collector
// Bus initiator for the 16-bit entropy peripheral. After reset it writes the
// two ring-oscillator control bytes, then repeatedly waits SAMPLE_DELAY
// cycles and reads the P and N sample words. Each P^N sample is 16 bits;
// two consecutive samples form one 32-bit word (first sample in the upper
// half) pushed into a show-ahead FIFO that feeds a valid/ready consumer.
// Ports: clk, nreset (sync, active-low), enable (gates new sample pairs),
//        bus (entropy_collector_if.master: peripheral bus + word stream).
// -----------------------------------------------------------------------------
module entropy_collector
    import entropy_pkg::*;
#(
    parameter logic [7:0] RNG1_INIT    = 8'h55,
    parameter logic [7:0] RNG2_INIT    = 8'haa,
    parameter int         SAMPLE_DELAY = 16,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                enable,
    entropy_collector_if.master bus
);
    localparam int                LEVEL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_W-1:0] DELAY_LOAD = DATA_W'(SAMPLE_DELAY - 1);

    state_t             state;
    state_t             state_nxt;
    bus_req_t           bus_q;
    logic [DATA_W-1:0]  delay_ctr;
    logic [DATA_W-1:0]  p_reg;
    logic [DATA_W-1:0]  hi_reg;
    logic               half;
    logic [DATA_W-1:0]  sample;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WORD_W-1:0]  fifo_rdata;
    logic [LEVEL_W-1:0] fifo_level;

    // Bus request presented while the FSM sits in a given state.
    function automatic bus_req_t decode(state_t st);
        bus_req_t r;
        r = '0;
        case (st)
            ST_WR1: begin
                r.cs     = 1'b1;
                r.we     = 1'b1;
                r.addr   = ADDR_ENT_WR_RNG1;
                r.dwrite = {RNG1_INIT, 8'h00};
            end
            ST_WR2: begin
                r.cs     = 1'b1;
                r.we     = 1'b1;
                r.addr   = ADDR_ENT_WR_RNG2;
                r.dwrite = {8'h00, RNG2_INIT};
            end
            ST_RD_P: begin
                r.cs   = 1'b1;
                r.addr = ADDR_ENT_RD_P;
            end
            ST_RD_N: begin
                r.cs   = 1'b1;
                r.addr = ADDR_ENT_RD_N;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // A pair is only started when the FIFO has room; since nothing else
    // pushes, the room is still there when the second half completes.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_START: state_nxt = ST_WR1;
            ST_WR1:   state_nxt = ST_WR2;
            ST_WR2:   state_nxt = ST_WAIT;
            ST_WAIT:  if (delay_ctr == '0 && enable && !fifo_full) state_nxt = ST_RD_P;
            ST_RD_P:  state_nxt = ST_RD_N;
            ST_RD_N:  state_nxt = ST_WAIT;
            default:  state_nxt = ST_START;
        endcase
    end

    assign sample = p_reg ^ bus.dread;
    assign push   = (state == ST_RD_N) && half;

    // Bus outputs are registered from the next state, so they track the
    // state register exactly while coming straight out of flops.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state     <= ST_START;
            bus_q     <= '0;
            delay_ctr <= '0;
            p_reg     <= '0;
            hi_reg    <= '0;
            half      <= 1'b0;
        end else begin
            state <= state_nxt;
            bus_q <= decode(state_nxt);

            if (state_nxt == ST_WAIT && state != ST_WAIT) begin
                delay_ctr <= DELAY_LOAD;
            end else if (state == ST_WAIT && delay_ctr != '0) begin
                delay_ctr <= delay_ctr - DATA_W'(1);
            end

            if (state == ST_RD_P) begin
                p_reg <= bus.dread;
            end

            // A stalled partial word keeps hi_reg/half until the pair resumes.
            if (state == ST_RD_N) begin
                if (!half) begin
                    hi_reg <= sample;
                    half   <= 1'b1;
                end else begin
                    half   <= 1'b0;
                end
            end
        end
    end

    assign pop = !fifo_empty && bus.rnd_ready;

    entropy_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (push),
        .wdata  ({hi_reg, sample}),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    assign bus.cs        = bus_q.cs;
    assign bus.we        = bus_q.we;
    assign bus.addr      = bus_q.addr;
    assign bus.dwrite    = bus_q.dwrite;
    assign bus.rnd_data  = fifo_rdata;
    assign bus.rnd_valid = !fifo_empty;
    assign bus.rnd_level = fifo_level;
endmodule
